// File: rtl/udma_traffic_gen_sched.sv
// Round-robin scheduler sharing one uDMA RX channel among N_SRC streams, tagging each word with its source.
// Latency: zero-cycle combinational src->rx path in GRANT; one ARB bubble per grant. Optional counters: UDMA_TGEN_SCHED_STATS_EN.
// Backpressure: rx_ready_i is forwarded only to the granted source; a presented word is never abandoned.
module udma_traffic_gen_sched #(
    parameter int N_SRC   = 4,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 8,
    parameter int SRC_W   = $clog2(N_SRC)
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         cfg_en_i,
    input  logic [BURST_W-1:0]           cfg_burst_i,
    input  logic [N_SRC-1:0]             cfg_mask_i,
    input  logic [N_SRC-1:0][DATA_W-1:0] src_data_i,
    input  logic [N_SRC-1:0]             src_valid_i,
    output logic [N_SRC-1:0]             src_ready_o,
    output logic [DATA_W-1:0]            rx_data_o,
    output logic [SRC_W-1:0]             rx_src_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    output logic                         busy_o,
    input  logic                         stat_clr_i,
    output logic [N_SRC-1:0][15:0]       stat_cnt_o
);

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

    state_t             cs, ns;
    logic [SRC_W-1:0]   gnt_idx, gnt_nxt;
    logic [SRC_W-1:0]   last_idx, last_nxt;
    logic [BURST_W-1:0] beat_cnt, beat_nxt;
    logic [BURST_W-1:0] burst_last;
    logic [N_SRC-1:0]   req;
    logic [SRC_W-1:0]   cand, pick_idx;
    logic               pick_found;
    logic               hs;

    assign req = src_valid_i & cfg_mask_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cs       <= IDLE;
            gnt_idx  <= '0;
            last_idx <= SRC_W'(N_SRC - 1);
            beat_cnt <= '0;
        end else begin
            cs       <= ns;
            gnt_idx  <= gnt_nxt;
            last_idx <= last_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_comb begin
        ns          = cs;
        gnt_nxt     = gnt_idx;
        last_nxt    = last_idx;
        beat_nxt    = beat_cnt;
        rx_valid_o  = 1'b0;
        rx_data_o   = '0;
        rx_src_o    = '0;
        src_ready_o = '0;
        busy_o      = 1'b0;
        hs          = 1'b0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        cand        = '0;
        // A burst setting of zero behaves as a single-word burst.
        burst_last  = (cfg_burst_i == '0) ? '0 : cfg_burst_i - BURST_W'(1);

        // Search starts just after the last served source so every source gets its turn.
        for (int k = 1; k <= N_SRC; k++) begin
            cand = SRC_W'((int'(last_idx) + k) % N_SRC);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end

        case (cs)
            IDLE: begin
                if (cfg_en_i) ns = ARB;
            end
            ARB: begin
                if (!cfg_en_i) begin
                    ns = IDLE;
                end else if (pick_found) begin
                    gnt_nxt  = pick_idx;
                    beat_nxt = '0;
                    ns       = GRANT;
                end
            end
            GRANT: begin
                busy_o                = 1'b1;
                rx_valid_o            = src_valid_i[gnt_idx] & cfg_mask_i[gnt_idx];
                rx_data_o             = src_data_i[gnt_idx];
                rx_src_o              = gnt_idx;
                src_ready_o[gnt_idx]  = rx_ready_i & cfg_mask_i[gnt_idx];
                hs                    = rx_valid_o & rx_ready_i;
                if (hs) beat_nxt = beat_cnt + BURST_W'(1);
                // Disable only takes effect once the presented word is accepted or withdrawn.
                if ((hs && (beat_cnt == burst_last)) || !rx_valid_o || (!cfg_en_i && hs)) begin
                    last_nxt = gnt_idx;
                    ns       = cfg_en_i ? ARB : IDLE;
                end
            end
            default: ns = IDLE;
        endcase
    end

`ifdef UDMA_TGEN_SCHED_STATS_EN
    logic [N_SRC-1:0][15:0] stat_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_q <= '0;
        end else if (stat_clr_i) begin
            stat_q <= '0;
        end else if (hs && (stat_q[gnt_idx] != 16'hFFFF)) begin
            stat_q[gnt_idx] <= stat_q[gnt_idx] + 16'd1;
        end
    end

    assign stat_cnt_o = stat_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr_i;
    assign stat_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_udma_traffic_gen_sched.sv
// Bench for udma_traffic_gen_sched: directed scenarios plus random traffic against a per-cycle reference model.
module tb_udma_traffic_gen_sched;

    localparam int N = 4;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              cfg_en;
    logic [7:0]        cfg_burst;
    logic [N-1:0]      cfg_mask;
    logic [N-1:0][31:0] src_data;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [31:0]       rx_data;
    logic [1:0]        rx_src;
    logic              rx_valid;
    logic              rx_ready;
    logic              busy;
    logic              stat_clr;
    logic [N-1:0][15:0] stat_cnt;

    udma_traffic_gen_sched #(.N_SRC(N), .DATA_W(32), .BURST_W(8)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cfg_en_i    (cfg_en),
        .cfg_burst_i (cfg_burst),
        .cfg_mask_i  (cfg_mask),
        .src_data_i  (src_data),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .rx_data_o   (rx_data),
        .rx_src_o    (rx_src),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (rx_ready),
        .busy_o      (busy),
        .stat_clr_i  (stat_clr),
        .stat_cnt_o  (stat_cnt)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: 0 idle, 1 arbitrating, 2 serving m_owner.
    int         m_mode, m_owner, m_last;
    logic [7:0] m_sent;
    int         m_stat [N];
    logic       m_hs;
    int         q_hs [$];
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_owner = 0;
        m_last  = N - 1;
        m_sent  = 8'd0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
    endtask

    task automatic chk_out();
        logic         ev;
        logic [31:0]  ed;
        int           es;
        logic [N-1:0] er;
        ev = 1'b0; ed = '0; es = 0; er = '0;
        if (m_mode == 2) begin
            ev          = src_valid[m_owner] & cfg_mask[m_owner];
            ed          = src_data[m_owner];
            es          = m_owner;
            er[m_owner] = rx_ready & cfg_mask[m_owner];
        end
        chk("rx_valid", 32'(rx_valid), 32'(ev));
        chk("rx_data", rx_data, ed);
        chk("rx_src", 32'(rx_src), 32'(es));
        chk("src_ready", 32'(src_ready), 32'(er));
        chk("busy", 32'(busy), 32'(m_mode == 2));
        for (int i = 0; i < N; i++) begin
`ifdef UDMA_TGEN_SCHED_STATS_EN
            chk("stat_cnt", 32'(stat_cnt[i]), 32'(m_stat[i]));
`else
            chk("stat_cnt_tied", 32'(stat_cnt[i]), 32'd0);
`endif
        end
        m_hs = ev & rx_ready;
    endtask

    // Inputs are driven at the falling edge; outputs checked 1ns later, model advanced for the rising edge.
    task automatic step();
        logic [N-1:0] req;
        logic         done, found;
        int           lim, c;
        for (int i = 0; i < N; i++) src_data[i] = $urandom;
        #1;
        chk_out();
        if (m_hs) q_hs.push_back(m_owner);
        if (stat_clr) begin
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end else if (m_hs && m_stat[m_owner] < 65535) begin
            m_stat[m_owner]++;
        end
        case (m_mode)
            0: if (cfg_en) m_mode = 1;
            1: begin
                if (!cfg_en) begin
                    m_mode = 0;
                end else begin
                    req   = src_valid & cfg_mask;
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (!found && req[c]) begin
                            found   = 1'b1;
                            m_owner = c;
                            m_sent  = 8'd0;
                            m_mode  = 2;
                        end
                    end
                end
            end
            default: begin
                lim  = (cfg_burst == 8'd0) ? 1 : int'(cfg_burst);
                done = 1'b0;
                if (m_hs) begin
                    if (m_sent == 8'(lim - 1)) done = 1'b1;
                    m_sent = m_sent + 8'd1;
                end
                if (!(src_valid[m_owner] & cfg_mask[m_owner])) done = 1'b1;
                if (!cfg_en && m_hs) done = 1'b1;
                if (done) begin
                    m_last = m_owner;
                    m_mode = cfg_en ? 1 : 0;
                end
            end
        endcase
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_out();
        cfg_en   = 1'b0;
        rx_ready = 1'b1;
        repeat (4) step();
        q_hs.delete();
    endtask

    initial begin
        rstn_i    = 1'b0;
        cfg_en    = 1'b0;
        cfg_burst = 8'd0;
        cfg_mask  = '0;
        src_data  = '0;
        src_valid = '0;
        rx_ready  = 1'b0;
        stat_clr  = 1'b0;
        model_reset();
        @(negedge clk_i);
        // Outputs stay at reset values even with active-looking inputs.
        cfg_en = 1'b1; cfg_mask = '1; src_valid = '1; rx_ready = 1'b1;
        #1 chk_out();
        @(negedge clk_i);
        rstn_i = 1'b1;
        cfg_en = 1'b0;
        q_hs.delete();

        // All sources busy, burst 4: groups of four words per source in rotation.
        cfg_en = 1'b1; cfg_mask = 4'hF; cfg_burst = 8'd4; src_valid = 4'hF; rx_ready = 1'b1;
        repeat (40) step();
        chk("t1_words", 32'(q_hs.size()), 32'd31);
        for (int i = 0; i < 16; i++) chk("t1_seq", 32'(q_hs[i]), 32'((i / 4) % 4));

        // Burst 0 with a single requester: one word every two cycles.
        idle_out();
        cfg_en = 1'b1; cfg_burst = 8'd0; src_valid = 4'b0100;
        repeat (20) step();
        chk("t2_words", 32'(q_hs.size()), 32'd9);
        for (int i = 0; i < q_hs.size(); i++) chk("t2_src", 32'(q_hs[i]), 32'd2);

        // Masked sources are never served.
        idle_out();
        cfg_en = 1'b1; cfg_mask = 4'b1010; cfg_burst = 8'd2; src_valid = 4'hF;
        repeat (30) step();
        chk("t3_nonempty", 32'(q_hs.size() > 0), 32'd1);
        for (int i = 0; i < q_hs.size(); i++) chk("t3_src_odd", 32'(q_hs[i] % 2), 32'd1);

        // Disable while a word is stalled: the word is held, accepted, then idle.
        idle_out();
        cfg_mask = 4'hF; cfg_burst = 8'd4; src_valid = 4'b0001; rx_ready = 1'b0; cfg_en = 1'b1;
        repeat (3) step();
        cfg_en = 1'b0;
        repeat (3) step();
        rx_ready = 1'b1;
        step();
        #1;
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_valid_after", 32'(rx_valid), 32'd0);
        chk("t4_words", 32'(q_hs.size()), 32'd1);

        // Source 1 withdraws mid-burst; next grant goes to source 2.
        idle_out();
        cfg_mask = 4'hF; cfg_burst = 8'd8; src_valid = 4'b0010; rx_ready = 1'b1; cfg_en = 1'b1;
        repeat (4) step();
        src_valid = 4'b0100;
        step();
        src_valid = 4'b0110;
        repeat (2) step();
        chk("t5_words", 32'(q_hs.size()), 32'd3);
        chk("t5_w0", 32'(q_hs[0]), 32'd1);
        chk("t5_w1", 32'(q_hs[1]), 32'd1);
        chk("t5_w2", 32'(q_hs[2]), 32'd2);

        // Random traffic and configuration churn.
        for (int n = 0; n < 800; n++) begin
            src_valid = N'($urandom);
            rx_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) cfg_mask = N'($urandom);
            if ($urandom_range(0, 19) == 0) cfg_burst = 8'($urandom_range(0, 5));
            cfg_en   = ($urandom_range(0, 29) != 0);
            stat_clr = ($urandom_range(0, 49) == 0);
            step();
        end
        stat_clr = 1'b0;

        // Asynchronous reset in the middle of a burst.
        cfg_en = 1'b1; cfg_mask = 4'hF; cfg_burst = 8'd8; src_valid = 4'hF; rx_ready = 1'b1;
        repeat (4) step();
        #2 rstn_i = 1'b0;
        #1;
        model_reset();
        chk_out();
        chk("t7_valid_rst", 32'(rx_valid), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (6) step();

`ifdef UDMA_TGEN_SCHED_STATS_EN
        // Counter saturation, then clear during a transfer.
        idle_out();
        cfg_mask = 4'b0001; src_valid = 4'b0001; cfg_burst = 8'd255; rx_ready = 1'b1; cfg_en = 1'b1;
        repeat (70400) step();
        chk("t8_sat", 32'(stat_cnt[0]), 32'h0000FFFF);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        #1 chk("t8_clr", 32'(stat_cnt[0]), 32'(m_stat[0]));
        repeat (4) step();
`else
        stat_clr = 1'b1;
        repeat (3) step();
        stat_clr = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/udma_traffic_gen_sched.md
# udma_traffic_gen_sched

Round-robin scheduler that shares one uDMA RX channel among N_SRC traffic-generator RX streams. Each granted source forwards up to a configurable burst of words before the grant rotates, and every output word is tagged with its source index. It sits between the traffic-generator RX instances and the uDMA RX channel input of the external-peripheral wrapper.

## Interface
- N_SRC, 4, number of requesting streams (2..8)
- DATA_W, 32, data width
- BURST_W, 8, width of burst-length config
- SRC_W, $clog2(N_SRC), width of source tag (derived)
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  scheduler enable
- cfg_burst_i  in  BURST_W  max words per grant; 0 treated as 1
- cfg_mask_i  in  N_SRC  per-source enable; masked sources never granted
- src_data_i  in  N_SRC x DATA_W  per-source data
- src_valid_i  in  N_SRC  per-source valid
- src_ready_o  out  N_SRC  per-source ready
- rx_data_o  out  DATA_W  data to uDMA RX channel
- rx_src_o  out  SRC_W  index of source driving rx_data_o
- rx_valid_o  out  1  valid to uDMA
- rx_ready_i  in  1  ready from uDMA
- busy_o  out  1  high while in GRANT
- stat_clr_i  in  1  synchronous clear of all stat counters
- stat_cnt_o  out  N_SRC x 16  per-source accepted-word counters

## Operation
- State register CS in {IDLE, ARB, GRANT}; registers gnt_idx (SRC_W), last_idx (SRC_W), beat_cnt (BURST_W).
- IDLE: all outputs inactive. cfg_en_i=1 -> ARB.
- ARB: req = src_valid_i & cfg_mask_i. If cfg_en_i=0 -> IDLE. If req=0 stay. Else gnt_idx <= first set bit of req searching last_idx+1, last_idx+2, ... (mod N_SRC); beat_cnt <= 0; -> GRANT.
- GRANT: rx_valid_o = src_valid_i[gnt_idx] & cfg_mask_i[gnt_idx]; rx_data_o = src_data_i[gnt_idx]; rx_src_o = gnt_idx; src_ready_o[gnt_idx] = rx_ready_i & cfg_mask_i[gnt_idx]; all other src_ready_o = 0.
- Handshake hs = rx_valid_o & rx_ready_i. On hs: beat_cnt++.
- Exit GRANT (last_idx <= gnt_idx) when any holds:
  - hs and beat_cnt == max(cfg_burst_i,1)-1 (burst complete);
  - rx_valid_o = 0 (source idle or masked);
  - cfg_en_i = 0 and (hs or rx_valid_o = 0) — never abandons a presented, unaccepted word.
- Exit target: IDLE if cfg_en_i=0, else ARB.
- cfg_burst_i sampled every GRANT cycle; changing mid-burst applies to the remaining comparison.
- Unused gnt_idx values (N_SRC not power of 2) unreachable; default state -> IDLE.

## Timing
- Reset: CS=IDLE, last_idx=N_SRC-1 (source 0 wins first), gnt_idx=0, beat_cnt=0, rx_valid_o=0, rx_data_o=0, rx_src_o=0, src_ready_o=0, busy_o=0, stat_cnt_o=0.
- Data path is combinational in GRANT: zero-cycle latency src -> rx.
- Every grant costs one ARB bubble cycle; back-to-back sources: max throughput burst/(burst+1).
- Outside GRANT, rx_data_o and rx_src_o driven 0.
- Reset mid-burst: immediate return to reset values; in-flight word not transferred.
- Single requester with burst=1: alternates ARB/GRANT, one word per 2 cycles.

## Configuration
- UDMA_TGEN_SCHED_STATS_EN defined: per-source 16-bit counters increment on each hs for gnt_idx, saturate at 0xFFFF; stat_clr_i=1 clears all, clear wins over simultaneous increment.
- Not defined: no counter flops; stat_cnt_o tied to 0; stat_clr_i ignored; ports remain for uniform integration.

## Test plan
- Reset, cfg_en=1, mask=0xF, burst=4, all sources valid, rx_ready=1 -> rx_src_o sequence 0,0,0,0,1x4,2x4,3x4,0..., one bubble between groups.
- burst=0, only src2 valid -> one word per 2 cycles, rx_src_o=2, beat count behaves as burst=1.
- mask=0b1010, all valid -> only sources 1 and 3 granted, src_ready_o[0]/[2] never high.
- In GRANT with rx_ready=0 and word presented, drop cfg_en -> rx_valid_o holds until rx_ready=1, word accepted, then IDLE, busy_o=0.
- src1 drops valid after 2 of 8 words -> grant ends, ARB picks src2 next (not src1 again).
- STATS_EN: 70000 words from src0 -> stat_cnt_o[0]=0xFFFF; stat_clr_i during a hs -> counter reads 0 next cycle.
